// File: rtl/memstream_afull_fifo.sv
// Elastic FWFT buffer behind one memstream output stream: absorbs in-flight read
// words, drives afull back-pressure, and reports occupancy and its peak since reset.
module memstream_afull_fifo #(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 16,
    parameter int AFULL_MARGIN = 4,
    parameter int CW           = $clog2(DEPTH + 1)
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    input  logic [WIDTH-1:0] s_axis_tdata,
    output logic             afull,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic [WIDTH-1:0] m_axis_tdata,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    max_count
);
    localparam int              PW       = $clog2(DEPTH);
    localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0]   AFULL_TH = CW'(DEPTH - AFULL_MARGIN);
    localparam logic [PW-1:0]   LAST     = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic [CW-1:0]    max_r;
    logic             ready_r;
    logic             afull_r;
    logic             push;
    logic             pop;

    // Handshake: a beat transfers on a rising edge where valid and ready are both 1;
    // valid never depends on ready, and ready here is registered so a full buffer
    // refuses a push even when a pop happens on the same edge.
    assign push = s_axis_tvalid & ready_r;
    assign pop  = m_axis_tvalid & m_axis_tready;

    assign m_axis_tvalid = (cnt != '0);
    assign m_axis_tdata  = mem[rp];
    assign s_axis_tready = ready_r;
    assign afull         = afull_r;
    assign count         = cnt;
    assign max_count     = max_r;

    always_comb begin
        cnt_next = cnt + CW'(push) - CW'(pop);
    end

    // Depth need not be a power of two, so pointers wrap by explicit compare.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wp      <= '0;
            rp      <= '0;
            cnt     <= '0;
            max_r   <= '0;
            ready_r <= 1'b0;
            afull_r <= 1'b1;
        end else begin
            if (push) wp <= bump(wp);
            if (pop)  rp <= bump(rp);
            cnt     <= cnt_next;
            ready_r <= (cnt_next < DEPTH_C);
            afull_r <= (cnt_next >= AFULL_TH);
            if (cnt_next > max_r) max_r <= cnt_next;
        end
    end

    // Storage is left unreset; stale words are unreachable once cnt is cleared.
    always_ff @(posedge aclk) begin
        if (push) mem[wp] <= s_axis_tdata;
    end

endmodule

// File: tb/tb_memstream_afull_fifo.sv
// Bench for memstream_afull_fifo: directed scenarios plus a queue-based reference
// model compared against the DUT outputs every cycle.
module tb_memstream_afull_fifo;
    localparam int W  = 70;
    localparam int D  = 8;
    localparam int AM = 3;
    localparam int CW = $clog2(D + 1);

    logic          aclk;
    logic          aresetn;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [W-1:0]  s_axis_tdata;
    logic          afull;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [W-1:0]  m_axis_tdata;
    logic [CW-1:0] count;
    logic [CW-1:0] max_count;

    memstream_afull_fifo #(.WIDTH(W), .DEPTH(D), .AFULL_MARGIN(AM)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .afull         (afull),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .count         (count),
        .max_count     (max_count)
    );

    // ---------------- clock ----------------
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // ---------------- scoreboard ----------------
    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] exp_q[$];
    logic         mdl_ready = 1'b0;
    logic         mdl_afull = 1'b1;
    int           mdl_max   = 0;
    logic         model_live = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a word queue; flags derive from its size after each edge.
    always @(posedge aclk) begin
        if (!aresetn) begin
            exp_q.delete();
            mdl_ready  = 1'b0;
            mdl_afull  = 1'b1;
            mdl_max    = 0;
            model_live = 1'b1;
        end else if (model_live) begin
            logic do_push;
            logic do_pop;
            do_push = s_axis_tvalid && mdl_ready;
            do_pop  = m_axis_tready && (exp_q.size() > 0);
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(s_axis_tdata);
            mdl_ready = (exp_q.size() < D);
            mdl_afull = (exp_q.size() >= D - AM);
            if (exp_q.size() > mdl_max) mdl_max = exp_q.size();
        end
    end

    always @(negedge aclk) begin
        if (model_live) begin
            chk("cmp_ready", W'(s_axis_tready), W'(mdl_ready));
            chk("cmp_afull", W'(afull), W'(mdl_afull));
            chk("cmp_count", W'(count), W'(exp_q.size()));
            chk("cmp_max", W'(max_count), W'(mdl_max));
            chk("cmp_valid", W'(m_axis_tvalid), W'(exp_q.size() != 0));
            if (exp_q.size() != 0) chk("cmp_data", m_axis_tdata, exp_q[0]);
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic         ms_v [3];
    logic [W-1:0] ms_d [3];
    logic [W-1:0] w;

    initial begin
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b0;

        // Reset values
        repeat (5) step();
        chk("rst_ready", W'(s_axis_tready), W'(0));
        chk("rst_afull", W'(afull), W'(1));
        chk("rst_valid", W'(m_axis_tvalid), W'(0));
        chk("rst_count", W'(count), W'(0));
        aresetn = 1'b1;
        step();
        chk("rel_ready", W'(s_axis_tready), W'(1));
        chk("rel_afull", W'(afull), W'(0));

        // Fill with consumer stalled; word 9 must bounce off a full buffer
        for (int i = 1; i <= 9; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = W'(i);
            step();
            chk("fill_count", W'(count), W'((i < 8) ? i : 8));
            chk("fill_afull", W'(afull), W'((i >= 5) ? 1 : 0));
            chk("fill_ready", W'(s_axis_tready), W'((i >= 8) ? 0 : 1));
        end
        s_axis_tvalid = 1'b0;
        chk("full_max", W'(max_count), W'(8));

        // Drain in order
        m_axis_tready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain_data", m_axis_tdata, W'(i));
            chk("drain_valid", W'(m_axis_tvalid), W'(1));
            step();
            chk("drain_count", W'(count), W'(8 - i));
            chk("drain_afull", W'(afull), W'(((8 - i) >= 5) ? 1 : 0));
        end
        chk("drain_empty", W'(m_axis_tvalid), W'(0));

        // Back-to-back streaming through the wrap point
        for (int i = 0; i < 100; i++) begin
            w = rand_word();
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = w;
            step();
            chk("stream_valid", W'(m_axis_tvalid), W'(1));
            chk("stream_data", m_axis_tdata, w);
            chk("stream_count", W'(count), W'(1));
        end
        s_axis_tvalid = 1'b0;
        step();
        chk("stream_end", W'(count), W'(0));

        // Push and pop together while full
        m_axis_tready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = W'(256 + i);
            step();
        end
        chk("sim_full", W'(count), W'(8));
        s_axis_tdata  = W'(12'h1FF);
        m_axis_tready = 1'b1;
        step();
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        chk("sim_count", W'(count), W'(7));
        chk("sim_ready", W'(s_axis_tready), W'(1));
        chk("sim_afull", W'(afull), W'(1));
        chk("sim_head", m_axis_tdata, W'(257));
        m_axis_tready = 1'b1;
        repeat (7) step();
        chk("sim_drained", W'(count), W'(0));

        // Random traffic from a latency-3 memstream that issues only while afull is low
        for (int k = 0; k < 3; k++) begin
            ms_v[k] = 1'b0;
            ms_d[k] = '0;
        end
        for (int c = 0; c < 5000; c++) begin
            s_axis_tvalid = ms_v[2];
            s_axis_tdata  = ms_d[2];
            ms_v[2] = ms_v[1]; ms_d[2] = ms_d[1];
            ms_v[1] = ms_v[0]; ms_d[1] = ms_d[0];
            ms_v[0] = !afull && ($urandom_range(0, 3) != 0);
            ms_d[0] = rand_word();
            m_axis_tready = ($urandom_range(0, 1) == 1);
            if (s_axis_tvalid) chk("inflight_ready", W'(s_axis_tready), W'(1));
            step();
        end
        m_axis_tready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (!s_axis_tvalid && !ms_v[0] && !ms_v[1] && !ms_v[2] && exp_q.size() == 0) break;
            s_axis_tvalid = ms_v[2];
            s_axis_tdata  = ms_d[2];
            ms_v[2] = ms_v[1]; ms_d[2] = ms_d[1];
            ms_v[1] = ms_v[0]; ms_d[1] = ms_d[0];
            ms_v[0] = 1'b0;
            if (s_axis_tvalid) chk("inflight_ready", W'(s_axis_tready), W'(1));
            step();
        end
        s_axis_tvalid = 1'b0;
        chk("rand_drain", W'(exp_q.size()), W'(0));

        // Reset in the middle of traffic
        m_axis_tready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = W'(16 + i);
            step();
        end
        s_axis_tvalid = 1'b0;
        chk("mid_count6", W'(count), W'(6));
        aresetn = 1'b0;
        step();
        chk("mid_count", W'(count), W'(0));
        chk("mid_max", W'(max_count), W'(0));
        chk("mid_valid", W'(m_axis_tvalid), W'(0));
        chk("mid_afull", W'(afull), W'(1));
        chk("mid_ready", W'(s_axis_tready), W'(0));
        aresetn = 1'b1;
        step();
        chk("mid_rel_ready", W'(s_axis_tready), W'(1));
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = W'(12'hABC);
        step();
        s_axis_tvalid = 1'b0;
        chk("mid_new_valid", W'(m_axis_tvalid), W'(1));
        chk("mid_new_data", m_axis_tdata, W'(12'hABC));
        chk("mid_new_count", W'(count), W'(1));
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
